// File: rtl/mul_chain_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mul_chain_pkg                                                |
// | Description : Shared widths and helpers for the multiply-chain scheduler.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mul_chain_pkg;

    localparam int MC_DW    = 16;
    localparam int MC_YW    = 32;
    localparam int MC_NREQ  = 4;
    localparam int MC_CNT_W = 16;

    typedef logic [MC_CNT_W-1:0] op_count_t;

    // Requester index width; never narrower than one bit so a lone requester still has an id port.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_chain_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mul_chain_pipe                                               |
// | Description : Two-stage enabled pipeline computing (a*b)*c modulo 2^YW.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mul_chain_pipe
    import mul_chain_pkg::*;
#(
    parameter int DW = MC_DW,
    parameter int YW = MC_YW,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          in_valid,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] c,
    input  logic [IW-1:0] id,
    output logic          s1_valid,
    output logic          s2_valid,
    output logic [YW-1:0] y,
    output logic [IW-1:0] y_id
);

    logic          r_v1;
    logic [YW-1:0] r_m1;
    logic [DW-1:0] r_c1;
    logic [IW-1:0] r_id1;
    logic          r_v2;
    logic [YW-1:0] r_y;
    logic [IW-1:0] r_id2;

    logic [YW-1:0] w_m1;
    logic [YW-1:0] w_y;

    // Multiplying in YW-bit arithmetic gives the modulo-2^YW result directly.
    assign w_m1 = YW'(a) * YW'(b);
    assign w_y  = r_m1 * YW'(r_c1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1  <= 1'b0;
            r_m1  <= '0;
            r_c1  <= '0;
            r_id1 <= '0;
            r_v2  <= 1'b0;
            r_y   <= '0;
            r_id2 <= '0;
        end else if (en) begin
            r_v1  <= in_valid;
            r_m1  <= w_m1;
            r_c1  <= c;
            r_id1 <= id;
            r_v2  <= r_v1;
            r_y   <= w_y;
            r_id2 <= r_id1;
        end
    end

    assign s1_valid = r_v1;
    assign s2_valid = r_v2;
    assign y        = r_y;
    assign y_id     = r_id2;

endmodule
`default_nettype wire

// File: rtl/mul_chain_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mul_chain_sched                                              |
// | Description : Round-robin arbiter sharing one multiply chain among NREQ    |
// |               requesters, with output backpressure and response counter.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mul_chain_sched
    import mul_chain_pkg::*;
#(
    parameter int NREQ = MC_NREQ,
    parameter int DW   = MC_DW,
    parameter int YW   = MC_YW
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ*DW-1:0]          req_a,
    input  logic [NREQ*DW-1:0]          req_b,
    input  logic [NREQ*DW-1:0]          req_c,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [id_width(NREQ)-1:0]   rsp_id,
    output logic [YW-1:0]               rsp_y,
    output logic                        busy,
    output logic [MC_CNT_W-1:0]         op_count
);

    localparam int IW = id_width(NREQ);

    logic [IW-1:0]   r_ptr;
    op_count_t       r_count;

    logic            w_stall;
    logic            w_take;
    logic            w_rsp_fire;
    logic            w_grant_any;
    logic [IW-1:0]   w_grant_idx;
    logic [IW:0]     w_pick;
    logic [NREQ-1:0] w_onehot;
    logic [DW-1:0]   w_sel_a;
    logic [DW-1:0]   w_sel_b;
    logic [DW-1:0]   w_sel_c;
    logic            w_s1_valid;
    logic            w_s2_valid;

    // Returns {found, index}; scanning offsets downward lets the smallest offset from p win.
    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] v, input logic [IW-1:0] p);
        logic [IW:0]   res;
        logic [IW-1:0] li;
        int            idx;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % NREQ;
            li  = IW'(idx);
            if (v[li]) begin
                res = {1'b1, li};
            end
        end
        return res;
    endfunction

    assign w_stall     = w_s2_valid & ~rsp_ready;
    assign w_pick      = rr_pick(req_valid, r_ptr);
    assign w_grant_any = w_pick[IW];
    assign w_grant_idx = w_pick[IW-1:0];
    assign w_take      = w_grant_any & ~w_stall & ~reset;
    assign w_rsp_fire  = w_s2_valid & rsp_ready;

    always_comb begin
        w_onehot = '0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_c  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant_idx == IW'(i)) begin
                w_onehot[i] = 1'b1;
                w_sel_a     = req_a[i*DW +: DW];
                w_sel_b     = req_b[i*DW +: DW];
                w_sel_c     = req_c[i*DW +: DW];
            end
        end
    end

    assign req_ready = w_take ? w_onehot : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_take) begin
            if (w_grant_idx == IW'(NREQ - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_grant_idx + IW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_rsp_fire && (r_count != '1)) begin
            r_count <= r_count + op_count_t'(1);
        end
    end

    mul_chain_pipe #(
        .DW (DW),
        .YW (YW),
        .IW (IW)
    ) u_pipe (
        .clk      (clk),
        .reset    (reset),
        .en       (~w_stall),
        .in_valid (w_take),
        .a        (w_sel_a),
        .b        (w_sel_b),
        .c        (w_sel_c),
        .id       (w_grant_idx),
        .s1_valid (w_s1_valid),
        .s2_valid (w_s2_valid),
        .y        (rsp_y),
        .y_id     (rsp_id)
    );

    assign rsp_valid = w_s2_valid;
    assign busy      = w_s1_valid | w_s2_valid;
    assign op_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_mul_chain_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mul_chain_sched                                           |
// | Description : Randomised bench for mul_chain_sched with an in-order model. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mul_chain_sched;

    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int YW   = 32;
    localparam int IW   = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*DW-1:0]   req_a;
    logic [NREQ*DW-1:0]   req_b;
    logic [NREQ*DW-1:0]   req_c;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IW-1:0]        rsp_id;
    logic [YW-1:0]        rsp_y;
    logic                 busy;
    logic [15:0]          op_count;

    always #5 clk = ~clk;

    mul_chain_sched #(.NREQ(NREQ), .DW(DW), .YW(YW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .busy      (busy),
        .op_count  (op_count)
    );

    typedef struct {
        int          id;
        logic [31:0] y;
        int          pos;
    } op_t;

    op_t             q[$];
    int              m_ptr;
    int              m_cnt;
    int              last_grant;
    int              n_vec;
    int              n_bad;
    logic            checks_on;
    logic [NREQ-1:0] seen_ready;
    logic [NREQ-1:0] pv;
    logic [DW-1:0]   pa [NREQ];
    logic [DW-1:0]   pb [NREQ];
    logic [DW-1:0]   pc [NREQ];
    int              grants [5];
    int              exp_rr [5] = '{0, 1, 2, 3, 0};

    function automatic logic [31:0] model_y(input logic [15:0] a, input logic [15:0] b,
                                            input logic [15:0] c);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        p = 64'(p[31:0]) * 64'(c);
        return p[31:0];
    endfunction

    function automatic int pick();
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (pv[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic exp_rsp_valid();
        return (q.size() > 0) && (q[0].pos >= 2);
    endfunction

    function automatic logic exp_stall();
        return exp_rsp_valid() && !rsp_ready;
    endfunction

    function automatic int oh(input logic [NREQ-1:0] r);
        int n;
        n = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (r[i]) n = (n == -1) ? i : -2;
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]         = pv[i];
            req_a[i*DW +: DW]    = pa[i];
            req_b[i*DW +: DW]    = pb[i];
            req_c[i*DW +: DW]    = pc[i];
        end
    endtask

    task automatic compare();
        int              g;
        logic [NREQ-1:0] er;
        g  = pick();
        er = '0;
        if (!reset && !exp_stall() && g >= 0) er[g] = 1'b1;
        seen_ready = req_ready;
        check("req_ready", req_ready, er);
        check("rsp_valid", rsp_valid, exp_rsp_valid());
        if (exp_rsp_valid()) begin
            check("rsp_id", rsp_id, q[0].id);
            check("rsp_y", rsp_y, q[0].y);
        end
        check("busy", busy, q.size() != 0);
        check("op_count", op_count, m_cnt);
    endtask

    // Model step at a rising edge: retire, age everything in flight, then accept.
    task automatic update();
        int g;
        last_grant = -1;
        if (reset) begin
            q.delete();
            m_ptr = 0;
            m_cnt = 0;
        end else if (!exp_stall()) begin
            if (exp_rsp_valid() && rsp_ready) begin
                void'(q.pop_front());
                if (m_cnt < 65535) m_cnt++;
            end
            foreach (q[k]) q[k].pos++;
            g = pick();
            if (g >= 0) begin
                q.push_back('{g, model_y(pa[g], pb[g], pc[g]), 1});
                m_ptr      = (g + 1) % NREQ;
                last_grant = g;
            end
        end
    endtask

    task automatic cycle();
        drive();
        #1;
        if (checks_on) compare();
        @(posedge clk);
        update();
        @(negedge clk);
    endtask

    // A requester still waiting keeps valid and payload; others draw fresh values.
    task automatic gen(input int dens);
        for (int i = 0; i < NREQ; i++) begin
            if (!(pv[i] && last_grant != i)) begin
                pv[i] = ($urandom_range(99, 0) < dens);
                pa[i] = ($urandom_range(7, 0) == 0) ? 16'hFFFF : 16'($urandom);
                pb[i] = ($urandom_range(7, 0) == 0) ? 16'hFFFF : 16'($urandom);
                pc[i] = 16'($urandom);
            end
        end
    endtask

    initial begin
        n_vec      = 0;
        n_bad      = 0;
        checks_on  = 1'b0;
        m_ptr      = 0;
        m_cnt      = 0;
        last_grant = -1;
        seen_ready = '0;
        reset      = 1'b1;
        rsp_ready  = 1'b1;
        pv         = '0;
        for (int i = 0; i < NREQ; i++) begin
            pa[i] = '0;
            pb[i] = '0;
            pc[i] = '0;
        end
        drive();
        @(posedge clk);
        update();
        @(negedge clk);
        checks_on = 1'b1;

        // Reset held with every requester asking
        pv = '1;
        cycle();
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_y", rsp_y, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_op_count", op_count, 0);
        reset = 1'b0;
        pv    = '0;

        // Single op from requester 2
        pv[2] = 1'b1; pa[2] = 16'd3; pb[2] = 16'd5; pc[2] = 16'd7;
        cycle();
        pv = '0;
        check("single_busy", busy, 1);
        check("single_early", rsp_valid, 0);
        cycle();
        check("single_valid", rsp_valid, 1);
        check("single_y", rsp_y, 105);
        check("single_id", rsp_id, 2);
        cycle();
        check("single_count", op_count, 1);

        // Product wraps modulo 2^32 before the second multiply
        pv[0] = 1'b1; pa[0] = 16'hFFFF; pb[0] = 16'hFFFF; pc[0] = 16'h0002;
        cycle();
        pv = '0;
        cycle();
        check("wrap_y", rsp_y, 32'hFFFC0002);
        cycle();

        // Round-robin from pointer 0 with all requesters valid
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        pv    = '1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            grants[k] = oh(seen_ready);
            gen(100);
        end
        for (int k = 0; k < 5; k++) check("rr_grant", grants[k], exp_rr[k]);

        // Backpressure with a full pipeline
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("bp_ready", seen_ready, 0);
            gen(100);
        end
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            gen(100);
        end

        // Reset one cycle after two accepts
        pv = '1;
        cycle();
        gen(100);
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("midrst_valid", rsp_valid, 0);
        check("midrst_count", op_count, 0);
        pv = '1;
        cycle();
        check("midrst_grant", oh(seen_ready), 0);
        pv = '0;
        for (int k = 0; k < 3; k++) cycle();

        // Random traffic with random backpressure
        for (int k = 0; k < 3000; k++) begin
            rsp_ready = ($urandom_range(3, 0) != 0);
            gen(60);
            cycle();
        end

        // Counter saturation
        rsp_ready = 1'b1;
        reset     = 1'b1;
        cycle();
        reset = 1'b0;
        pv    = '1;
        for (int k = 0; k < 65540; k++) begin
            cycle();
            gen(100);
        end
        check("sat_count", op_count, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
